// File: rtl/iob_sim_iob_arbiter_pkg.sv
// rtl/iob_sim_iob_arbiter_pkg.sv - shared defaults and helpers for the IOb arbiter
package iob_sim_iob_arbiter_pkg;

    localparam int DEF_N_MASTERS  = 2;
    localparam int DEF_RD_DEPTH_W = 2;

    // Index width for n channels; a single channel still needs a 1-bit index
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iob_sim_arb_tag_fifo.sv
// rtl/iob_sim_arb_tag_fifo.sv - tag FIFO recording the issuing master of each outstanding read
module iob_sim_arb_tag_fifo #(
    parameter int W       = 1,
    parameter int DEPTH_W = 2
) (
    input  logic         clk_i,
    input  logic         arst_n_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int DEPTH = 1 << DEPTH_W;

    logic [W-1:0]       mem_q [DEPTH];
    logic [W-1:0]       mem_d [DEPTH];
    logic [DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_W:0]   count_q, count_d;
    logic               do_push, do_pop;

    assign full_o  = (count_q == (DEPTH_W + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    // Pointer/count update; a push into a full FIFO is allowed only when the head leaves in the same cycle
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push_i & (~full_o | pop_i);
        do_pop   = pop_i & ~empty_o;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + DEPTH_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (DEPTH_W + 1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (DEPTH_W + 1)'(1);
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/iob_sim_iob_arbiter.sv
// rtl/iob_sim_iob_arbiter.sv - round-robin N-master IOb arbiter with in-order read response routing
module iob_sim_iob_arbiter
    import iob_sim_iob_arbiter_pkg::*;
#(
    parameter int N_MASTERS  = DEF_N_MASTERS,
    parameter int ADDR_W     = 3,
    parameter int DATA_W     = 32,
    parameter int RD_DEPTH_W = DEF_RD_DEPTH_W
) (
    input  logic                            clk_i,
    input  logic                            arst_n_i,
    input  logic                            cke_i,
    input  logic [N_MASTERS-1:0]            m_avalid_i,
    input  logic [N_MASTERS*ADDR_W-1:0]     m_addr_i,
    input  logic [N_MASTERS*DATA_W-1:0]     m_wdata_i,
    input  logic [N_MASTERS*DATA_W/8-1:0]   m_wstrb_i,
    output logic [N_MASTERS-1:0]            m_ready_o,
    output logic [N_MASTERS-1:0]            m_rvalid_o,
    output logic [DATA_W-1:0]               m_rdata_o,
    output logic                            s_avalid_o,
    output logic [ADDR_W-1:0]               s_addr_o,
    output logic [DATA_W-1:0]               s_wdata_o,
    output logic [DATA_W/8-1:0]             s_wstrb_o,
    input  logic                            s_ready_i,
    input  logic                            s_rvalid_i,
    input  logic [DATA_W-1:0]               s_rdata_i,
    output logic                            err_o
);

    localparam int IDX_W  = idx_w(N_MASTERS);
    localparam int STRB_W = DATA_W / 8;

    logic               active;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;
    logic               lock_q, lock_d;
    logic               err_q, err_d;
    logic [IDX_W-1:0]   grant;
    logic               found;
    int                 idx;
    logic               g_avalid;
    logic               is_read;
    logic               accept;
    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [IDX_W-1:0]   fifo_head;

    // Nothing is issued or returned while in reset or with the clock enable low
    assign active    = arst_n_i & cke_i;
    assign err_o     = err_q;
    assign m_rdata_o = s_rdata_i;

    // Grant: a locked (stalled) request keeps its master, otherwise round-robin from rr_ptr
    always_comb begin
        grant = rr_ptr_q;
        found = 1'b0;
        idx   = 0;
        if (lock_q) begin
            grant = lock_idx_q;
        end else begin
            for (int i = 0; i < N_MASTERS; i++) begin
                idx = (int'(rr_ptr_q) + i) % N_MASTERS;
                if (!found && m_avalid_i[idx]) begin
                    found = 1'b1;
                    grant = IDX_W'(idx);
                end
            end
        end
    end

    // Request mux of the granted master's packed fields
    always_comb begin
        g_avalid  = 1'b0;
        s_addr_o  = '0;
        s_wdata_o = '0;
        s_wstrb_o = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (grant == IDX_W'(k)) begin
                g_avalid  = m_avalid_i[k];
                s_addr_o  = m_addr_i[k*ADDR_W +: ADDR_W];
                s_wdata_o = m_wdata_i[k*DATA_W +: DATA_W];
                s_wstrb_o = m_wstrb_i[k*STRB_W +: STRB_W];
            end
        end
    end

    // Request issue; a read needs a free tag slot, or the head slot retiring in this same cycle
    always_comb begin
        is_read    = ~|s_wstrb_o;
        s_avalid_o = active & g_avalid & ~(is_read & fifo_full & ~s_rvalid_i);
        accept     = s_avalid_o & s_ready_i;
        fifo_push  = accept & is_read;
        m_ready_o  = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (grant == IDX_W'(k)) begin
                m_ready_o[k] = accept;
            end
        end
    end

    // Response demux: the oldest outstanding read tag selects the master receiving rvalid
    always_comb begin
        fifo_pop   = active & s_rvalid_i & ~fifo_empty;
        m_rvalid_o = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (fifo_head == IDX_W'(k)) begin
                m_rvalid_o[k] = fifo_pop;
            end
        end
    end

    // Next state for round-robin pointer, lock and sticky error; frozen while cke_i is low
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        err_d      = err_q;
        if (cke_i) begin
            lock_d = s_avalid_o & ~s_ready_i;
            if (s_avalid_o) begin
                lock_idx_d = grant;
            end
            if (accept) begin
                rr_ptr_d = (int'(grant) == N_MASTERS - 1) ? '0 : grant + IDX_W'(1);
            end
            if (s_rvalid_i && fifo_empty) begin
                err_d = 1'b1;
            end
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            err_q      <= err_d;
        end
    end

    iob_sim_arb_tag_fifo #(
        .W       (IDX_W),
        .DEPTH_W (RD_DEPTH_W)
    ) u_tag_fifo (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .push_i   (fifo_push),
        .data_i   (grant),
        .pop_i    (fifo_pop),
        .data_o   (fifo_head),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty)
    );

endmodule

// File: tb/tb_iob_sim_iob_arbiter.sv
// tb/tb_iob_sim_iob_arbiter.sv - directed self-checking bench for iob_sim_iob_arbiter
module tb_iob_sim_iob_arbiter;

    logic        clk;
    logic        arst_n;
    logic        cke;
    logic [1:0]  m_avalid;
    logic [5:0]  m_addr;
    logic [63:0] m_wdata;
    logic [7:0]  m_wstrb;
    logic [1:0]  m_ready;
    logic [1:0]  m_rvalid;
    logic [31:0] m_rdata;
    logic        s_avalid;
    logic [2:0]  s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready;
    logic        s_rvalid;
    logic [31:0] s_rdata;
    logic        err;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    iob_sim_iob_arbiter #(
        .N_MASTERS  (2),
        .ADDR_W     (3),
        .DATA_W     (32),
        .RD_DEPTH_W (2)
    ) dut (
        .clk_i      (clk),
        .arst_n_i   (arst_n),
        .cke_i      (cke),
        .m_avalid_i (m_avalid),
        .m_addr_i   (m_addr),
        .m_wdata_i  (m_wdata),
        .m_wstrb_i  (m_wstrb),
        .m_ready_o  (m_ready),
        .m_rvalid_o (m_rvalid),
        .m_rdata_o  (m_rdata),
        .s_avalid_o (s_avalid),
        .s_addr_o   (s_addr),
        .s_wdata_o  (s_wdata),
        .s_wstrb_o  (s_wstrb),
        .s_ready_i  (s_ready),
        .s_rvalid_i (s_rvalid),
        .s_rdata_i  (s_rdata),
        .err_o      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        arst_n   = 1'b0;
        cke      = 1'b1;
        m_avalid = 2'b11;
        m_addr   = {3'h2, 3'h1};
        m_wdata  = {32'h2222_2222, 32'h1111_1111};
        m_wstrb  = 8'hFF;
        s_ready  = 1'b0;
        s_rvalid = 1'b0;
        s_rdata  = '0;
        @(negedge clk); #1;
        vec_cnt++; if (s_avalid !== 1'b0) begin miss_cnt++; $display("FAIL rst_s_avalid got %b exp 0", s_avalid); end
        vec_cnt++; if (m_ready !== 2'b00) begin miss_cnt++; $display("FAIL rst_m_ready got %b exp 00", m_ready); end
        vec_cnt++; if (err !== 1'b0) begin miss_cnt++; $display("FAIL rst_err got %b exp 0", err); end
        vec_cnt++; if (m_rvalid !== 2'b00) begin miss_cnt++; $display("FAIL rst_m_rvalid got %b exp 00", m_rvalid); end
        @(negedge clk);
        arst_n = 1'b1;
        #1;
        vec_cnt++; if (s_avalid !== 1'b1) begin miss_cnt++; $display("FAIL rel_s_avalid got %b exp 1", s_avalid); end
        vec_cnt++; if (s_addr !== 3'h1) begin miss_cnt++; $display("FAIL rel_grant0_addr got %h exp 1", s_addr); end
        m_avalid = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_fairness();
        logic [1:0]  exp_rdy [4];
        logic [31:0] exp_wd  [4];
        exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_wd  = '{32'h1111_1111, 32'h2222_2222, 32'h1111_1111, 32'h2222_2222};
        m_avalid = 2'b11;
        s_ready  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            vec_cnt++; if (m_ready !== exp_rdy[c]) begin miss_cnt++; $display("FAIL fair_ready[%0d] got %b exp %b", c, m_ready, exp_rdy[c]); end
            vec_cnt++; if (s_wdata !== exp_wd[c]) begin miss_cnt++; $display("FAIL fair_wdata[%0d] got %h exp %h", c, s_wdata, exp_wd[c]); end
            @(negedge clk);
        end
        m_avalid = 2'b00;
        s_ready  = 1'b0;
    endtask

    task automatic test_lock();
        m_avalid = 2'b10;
        #1;
        vec_cnt++; if (s_addr !== 3'h2 || s_avalid !== 1'b1) begin miss_cnt++; $display("FAIL lock_first got addr %h avalid %b exp 2/1", s_addr, s_avalid); end
        @(negedge clk);
        m_avalid = 2'b11;
        for (int c = 0; c < 2; c++) begin
            #1;
            vec_cnt++; if (s_addr !== 3'h2) begin miss_cnt++; $display("FAIL lock_hold[%0d] addr got %h exp 2", c, s_addr); end
            vec_cnt++; if (m_ready !== 2'b00) begin miss_cnt++; $display("FAIL lock_hold_rdy[%0d] got %b exp 00", c, m_ready); end
            @(negedge clk);
        end
        s_ready = 1'b1;
        #1;
        vec_cnt++; if (m_ready !== 2'b10) begin miss_cnt++; $display("FAIL lock_accept got %b exp 10", m_ready); end
        @(negedge clk); #1;
        vec_cnt++; if (m_ready !== 2'b01) begin miss_cnt++; $display("FAIL lock_after got %b exp 01", m_ready); end
        @(negedge clk);
        m_avalid = 2'b00;
    endtask

    task automatic test_routing();
        m_wstrb  = 8'h00;
        s_ready  = 1'b1;
        m_avalid = 2'b01;
        #1;
        vec_cnt++; if (m_ready !== 2'b01) begin miss_cnt++; $display("FAIL rt_rd0 got %b exp 01", m_ready); end
        @(negedge clk);
        m_avalid = 2'b10;
        #1;
        vec_cnt++; if (m_ready !== 2'b10) begin miss_cnt++; $display("FAIL rt_rd1 got %b exp 10", m_ready); end
        @(negedge clk);
        m_avalid = 2'b00;
        s_rvalid = 1'b1;
        s_rdata  = 32'hAAAA_0001;
        #1;
        vec_cnt++; if (m_rvalid !== 2'b01 || m_rdata !== 32'hAAAA_0001) begin miss_cnt++; $display("FAIL rt_resp0 got %b/%h exp 01/AAAA0001", m_rvalid, m_rdata); end
        @(negedge clk);
        s_rdata = 32'hBBBB_0002;
        #1;
        vec_cnt++; if (m_rvalid !== 2'b10 || m_rdata !== 32'hBBBB_0002) begin miss_cnt++; $display("FAIL rt_resp1 got %b/%h exp 10/BBBB0002", m_rvalid, m_rdata); end
        @(negedge clk);
        s_rvalid = 1'b0;
        m_wstrb  = 8'h0F;
        m_avalid = 2'b01;
        #1;
        vec_cnt++; if (m_ready !== 2'b01) begin miss_cnt++; $display("FAIL rt_wr got %b exp 01", m_ready); end
        @(negedge clk);
        m_avalid = 2'b00;
        #1;
        vec_cnt++; if (m_rvalid !== 2'b00 || err !== 1'b0) begin miss_cnt++; $display("FAIL rt_wr_norv got %b err %b exp 00/0", m_rvalid, err); end
        @(negedge clk);
    endtask

    task automatic test_full();
        m_wstrb  = 8'hF0;
        m_avalid = 2'b01;
        s_ready  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            vec_cnt++; if (m_ready !== 2'b01) begin miss_cnt++; $display("FAIL full_fill[%0d] got %b exp 01", c, m_ready); end
            @(negedge clk);
        end
        #1;
        vec_cnt++; if (s_avalid !== 1'b0 || m_ready !== 2'b00) begin miss_cnt++; $display("FAIL full_block got %b/%b exp 0/00", s_avalid, m_ready); end
        @(negedge clk);
        m_avalid = 2'b11;
        #1;
        vec_cnt++; if (m_ready !== 2'b10 || s_wstrb !== 4'hF) begin miss_cnt++; $display("FAIL full_wr got %b/%h exp 10/F", m_ready, s_wstrb); end
        @(negedge clk);
        m_avalid = 2'b01;
        s_rvalid = 1'b1;
        s_rdata  = 32'hC0DE_0000;
        #1;
        vec_cnt++; if (m_ready !== 2'b01 || m_rvalid !== 2'b01) begin miss_cnt++; $display("FAIL full_pushpop got %b/%b exp 01/01", m_ready, m_rvalid); end
        @(negedge clk);
        s_rvalid = 1'b0;
        #1;
        vec_cnt++; if (s_avalid !== 1'b0) begin miss_cnt++; $display("FAIL full_still4 got %b exp 0", s_avalid); end
        m_avalid = 2'b00;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            s_rvalid = 1'b1;
            s_rdata  = 32'h0000_0010 + 32'(c);
            #1;
            vec_cnt++; if (m_rvalid !== 2'b01 || m_rdata !== 32'h0000_0010 + 32'(c)) begin miss_cnt++; $display("FAIL full_drain[%0d] got %b/%h exp 01/%h", c, m_rvalid, m_rdata, 32'h0000_0010 + 32'(c)); end
        end
        @(negedge clk);
    endtask

    task automatic test_spurious();
        s_rvalid = 1'b1;
        s_rdata  = 32'hDEAD_BEEF;
        #1;
        vec_cnt++; if (m_rvalid !== 2'b00) begin miss_cnt++; $display("FAIL spur_rvalid got %b exp 00", m_rvalid); end
        @(negedge clk);
        s_rvalid = 1'b0;
        #1;
        vec_cnt++; if (err !== 1'b1) begin miss_cnt++; $display("FAIL spur_err got %b exp 1", err); end
        repeat (3) @(negedge clk);
        #1;
        vec_cnt++; if (err !== 1'b1) begin miss_cnt++; $display("FAIL spur_sticky got %b exp 1", err); end
        arst_n = 1'b0;
        #1;
        vec_cnt++; if (err !== 1'b0) begin miss_cnt++; $display("FAIL spur_rst got %b exp 0", err); end
        @(negedge clk);
        arst_n   = 1'b1;
        s_rvalid = 1'b1;
        @(negedge clk);
        s_rvalid = 1'b0;
        #1;
        vec_cnt++; if (err !== 1'b1) begin miss_cnt++; $display("FAIL late_rvalid_err got %b exp 1", err); end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_lock();
        test_routing();
        test_full();
        test_spurious();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
